// File: rtl/xbus_sequencer.sv
// xbus_sequencer: fetch-driven sequencer for the 8-bit multiplexed bus.
// Runs PC/INSTR phases, then data phases only when the core asks.
module xbus_sequencer #(
   parameter int WAIT_LIMIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ena,
   input  logic        ext_ready,
   input  logic [7:0]  bus_in,
   output logic [7:0]  bus_out,
   output logic        bus_oe,
   output logic [2:0]  phase,
   output logic        ext_we,
   input  logic [15:0] pc,
   input  logic [15:0] dmem_addr,
   input  logic [15:0] dmem_wdata,
   input  logic        dmem_we,
   input  logic        dmem_req,
   output logic [15:0] instr,
   output logic [15:0] dmem_rdata,
   output logic        core_step,
   output logic        timeout_err
);

   localparam int CW =
      (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIM_M1 =
      CW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

   typedef enum logic [3:0] {
      S_IDLE,
      S_PC_LO,
      S_PC_HI,
      S_INSTR_LO,
      S_INSTR_HI,
      S_DECODE,
      S_DADDR_LO,
      S_DADDR_HI,
      S_DDATA_LO,
      S_DDATA_HI
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [CW-1:0] wcnt_q;
   logic          we_q;
   logic          gated;
   logic          forced;
   logic          adv;

   // Bus phases wait on ext_ready; timeout forces the advance.
   always_comb begin
      gated  = 1'b0;
      forced = 1'b0;
      unique case (state_q)
         S_PC_LO, S_PC_HI,
         S_INSTR_LO, S_INSTR_HI,
         S_DADDR_LO, S_DADDR_HI,
         S_DDATA_LO, S_DDATA_HI: gated = 1'b1;
         default:                gated = 1'b0;
      endcase
      if (WAIT_LIMIT > 0)
         forced = gated && !ext_ready
                  && (wcnt_q == LIM_M1);
      adv = gated && (ext_ready || forced);
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (ena) state_d = S_PC_LO;
         S_PC_LO:
            if (adv) state_d = S_PC_HI;
         S_PC_HI:
            if (adv) state_d = S_INSTR_LO;
         S_INSTR_LO:
            if (adv) state_d = S_INSTR_HI;
         S_INSTR_HI:
            if (adv) state_d = S_DECODE;
         S_DECODE:
            if (dmem_req) state_d = S_DADDR_LO;
            else if (ena) state_d = S_PC_LO;
            else          state_d = S_IDLE;
         S_DADDR_LO:
            if (adv) state_d = S_DADDR_HI;
         S_DADDR_HI:
            if (adv) state_d = S_DDATA_LO;
         S_DDATA_LO:
            if (adv) state_d = S_DDATA_HI;
         S_DDATA_HI:
            if (adv) state_d = ena ? S_PC_LO : S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   // Moore bus outputs; core_step also uses the final advance.
   always_comb begin
      phase     = 3'd0;
      bus_oe    = 1'b0;
      bus_out   = 8'h00;
      ext_we    = 1'b0;
      core_step = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            phase = 3'd0;
         end
         S_PC_LO: begin
            phase   = 3'd0;
            bus_oe  = 1'b1;
            bus_out = pc[7:0];
         end
         S_PC_HI: begin
            phase   = 3'd1;
            bus_oe  = 1'b1;
            bus_out = pc[15:8];
         end
         S_INSTR_LO: begin
            phase = 3'd2;
         end
         S_INSTR_HI: begin
            phase = 3'd3;
         end
         S_DECODE: begin
            phase     = 3'd3;
            core_step = !dmem_req;
         end
         S_DADDR_LO: begin
            phase   = 3'd4;
            bus_oe  = 1'b1;
            bus_out = dmem_addr[7:0];
            ext_we  = we_q;
         end
         S_DADDR_HI: begin
            phase   = 3'd5;
            bus_oe  = 1'b1;
            bus_out = dmem_addr[15:8];
            ext_we  = we_q;
         end
         S_DDATA_LO: begin
            phase   = 3'd6;
            bus_oe  = we_q;
            bus_out = dmem_wdata[7:0];
            ext_we  = we_q;
         end
         S_DDATA_HI: begin
            phase     = 3'd7;
            bus_oe    = we_q;
            bus_out   = dmem_wdata[15:8];
            ext_we    = we_q;
            core_step = adv;
         end
         default: begin
            phase = 3'd0;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Wait counter: counts stalled cycles, clears on any move.
   always_ff @(posedge clk) begin
      if (rst || (state_d != state_q))
         wcnt_q <= '0;
      else if (gated && !ext_ready)
         wcnt_q <= wcnt_q + 1'b1;
   end

   // Captured instruction/load data, store flag, timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr       <= 16'h0000;
         dmem_rdata  <= 16'h0000;
         we_q        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         if (adv && state_q == S_INSTR_LO)
            instr[7:0] <= bus_in;
         if (adv && state_q == S_INSTR_HI)
            instr[15:8] <= bus_in;
         if (state_q == S_DECODE && dmem_req)
            we_q <= dmem_we;
         if (adv && !we_q && state_q == S_DDATA_LO)
            dmem_rdata[7:0] <= bus_in;
         if (adv && !we_q && state_q == S_DDATA_HI)
            dmem_rdata[15:8] <= bus_in;
         if (forced)
            timeout_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_xbus_sequencer.sv
// tb_xbus_sequencer: directed scoreboard bench for xbus_sequencer.
// Per-cycle bus expectations and per-instruction results are queued.
module tb_xbus_sequencer;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        ext_ready;
   logic [7:0]  bus_in;
   logic [7:0]  bus_out;
   logic        bus_oe;
   logic [2:0]  phase;
   logic        ext_we;
   logic [15:0] pc;
   logic [15:0] dmem_addr;
   logic [15:0] dmem_wdata;
   logic        dmem_we;
   logic        dmem_req;
   logic [15:0] instr;
   logic [15:0] dmem_rdata;
   logic        core_step;
   logic        timeout_err;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [2:0] ph;
      logic       oe;
      logic [7:0] bo;
      logic       we;
      logic       st;
   } cyc_t;

   typedef struct packed {
      logic [15:0] ins;
      logic [15:0] rd;
   } res_t;

   cyc_t sb[$];
   res_t rq[$];

   xbus_sequencer #(.WAIT_LIMIT(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .ena        (ena),
      .ext_ready  (ext_ready),
      .bus_in     (bus_in),
      .bus_out    (bus_out),
      .bus_oe     (bus_oe),
      .phase      (phase),
      .ext_we     (ext_we),
      .pc         (pc),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_we    (dmem_we),
      .dmem_req   (dmem_req),
      .instr      (instr),
      .dmem_rdata (dmem_rdata),
      .core_step  (core_step),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [15:0] obs,
                      input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic exp_res(input logic [15:0] ins,
                          input logic [15:0] rd);
      res_t r;
      r.ins = ins;
      r.rd  = rd;
      rq.push_back(r);
   endtask

   task automatic tick(input logic [7:0] bi,
                       input logic       rdy,
                       input logic [2:0] ph,
                       input logic       oe,
                       input logic [7:0] bo,
                       input logic       we,
                       input logic       st);
      cyc_t e;
      res_t r;
      logic saw;
      bus_in    = bi;
      ext_ready = rdy;
      e.ph = ph;
      e.oe = oe;
      e.bo = bo;
      e.we = we;
      e.st = st;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      chk("phase", 16'(phase), 16'(e.ph));
      chk("bus_oe", 16'(bus_oe), 16'(e.oe));
      chk("bus_out", 16'(bus_out), 16'(e.bo));
      chk("ext_we", 16'(ext_we), 16'(e.we));
      chk("core_step", 16'(core_step), 16'(e.st));
      saw = core_step;
      @(posedge clk);
      #1;
      if (saw === 1'b1) begin
         if (rq.size() == 0) begin
            total++;
            bad++;
            $error("FAIL step_extra obs=1 exp=0");
         end else begin
            r = rq.pop_front();
            chk("instr", instr, r.ins);
            chk("dmem_rdata", dmem_rdata, r.rd);
         end
      end
   endtask

   task automatic fetch(input logic [7:0] plo,
                        input logic [7:0] phi,
                        input logic [7:0] ilo,
                        input logic [7:0] ihi);
      tick(8'h00, 1'b1, 3'd0, 1'b1, plo, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd1, 1'b1, phi, 1'b0, 1'b0);
      tick(ilo,   1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(ihi,   1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      clk        = 1'b0;
      rst        = 1'b1;
      ena        = 1'b0;
      ext_ready  = 1'b1;
      bus_in     = 8'h00;
      pc         = 16'h0000;
      dmem_addr  = 16'h0000;
      dmem_wdata = 16'h0000;
      dmem_we    = 1'b0;
      dmem_req   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // reset state, parked with ena low
      tick(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_instr", instr, 16'h0000);
      chk("rst_rdata", dmem_rdata, 16'h0000);
      chk("rst_tmo", 16'(timeout_err), 16'h0000);

      // plain instruction, 5 cycles
      ena      = 1'b1;
      pc       = 16'h1234;
      dmem_req = 1'b0;
      exp_res(16'hABCD, 16'h0000);
      tick(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      fetch(8'h34, 8'h12, 8'hCD, 8'hAB);
      tick(8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1);

      // load, 9 cycles
      pc         = 16'h2000;
      dmem_req   = 1'b1;
      dmem_we    = 1'b0;
      dmem_addr  = 16'hBEEF;
      dmem_wdata = 16'h3344;
      exp_res(16'h2211, 16'h5678);
      fetch(8'h00, 8'h20, 8'h11, 8'h22);
      tick(8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd4, 1'b1, 8'hEF, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd5, 1'b1, 8'hBE, 1'b0, 1'b0);
      tick(8'h78, 1'b1, 3'd6, 1'b0, 8'h44, 1'b0, 1'b0);
      tick(8'h56, 1'b1, 3'd7, 1'b0, 8'h33, 1'b0, 1'b1);

      // store
      pc         = 16'h2002;
      dmem_we    = 1'b1;
      dmem_addr  = 16'h0102;
      dmem_wdata = 16'hA55A;
      exp_res(16'h4433, 16'h5678);
      fetch(8'h02, 8'h20, 8'h33, 8'h44);
      tick(8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd4, 1'b1, 8'h02, 1'b1, 1'b0);
      tick(8'h00, 1'b1, 3'd5, 1'b1, 8'h01, 1'b1, 1'b0);
      tick(8'hFF, 1'b1, 3'd6, 1'b1, 8'h5A, 1'b1, 1'b0);
      tick(8'hEE, 1'b1, 3'd7, 1'b1, 8'hA5, 1'b1, 1'b1);

      // wait states in INSTR_LO
      pc       = 16'h0004;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
      exp_res(16'h6655, 16'h5678);
      tick(8'h00, 1'b1, 3'd0, 1'b1, 8'h04, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(8'h99, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
         chk("wait_instr", instr, 16'h4433);
      end
      tick(8'h55, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h66, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("wait_tmo", 16'(timeout_err), 16'h0000);

      // timeout: every phase forced after 4 cycles
      pc = 16'h0006;
      exp_res(16'h8877, 16'h5678);
      for (int i = 0; i < 4; i++) begin
         tick(8'h00, 1'b0, 3'd0, 1'b1, 8'h06, 1'b0, 1'b0);
         chk("tmo_pclo", 16'(timeout_err), 16'(i == 3));
      end
      for (int i = 0; i < 4; i++)
         tick(8'h00, 1'b0, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         tick(8'h77, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++)
         tick(8'h88, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1);
      chk("tmo_sticky", 16'(timeout_err), 16'h0001);

      // ena dropped in PC_HI: finish, then park
      pc = 16'h0008;
      exp_res(16'h3412, 16'h5678);
      tick(8'h00, 1'b1, 3'd0, 1'b1, 8'h08, 1'b0, 1'b0);
      ena = 1'b0;
      tick(8'h00, 1'b1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b0);
      tick(8'h12, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h34, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b1);
      repeat (2)
         tick(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("idle_tmo", 16'(timeout_err), 16'h0001);

      // reset in DADDR_HI of a store
      ena       = 1'b1;
      pc        = 16'h000A;
      dmem_req  = 1'b1;
      dmem_we   = 1'b1;
      dmem_addr = 16'hC0DE;
      tick(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      fetch(8'h0A, 8'h00, 8'h01, 8'h02);
      tick(8'h00, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
      tick(8'h00, 1'b1, 3'd4, 1'b1, 8'hDE, 1'b1, 1'b0);
      rst = 1'b1;
      tick(8'h00, 1'b1, 3'd5, 1'b1, 8'hC0, 1'b1, 1'b0);
      rst = 1'b0;
      ena = 1'b0;
      tick(8'h00, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0);
      chk("post_rst_instr", instr, 16'h0000);
      chk("post_rst_rdata", dmem_rdata, 16'h0000);
      chk("post_rst_tmo", 16'(timeout_err), 16'h0000);
      chk("results_left", 16'(rq.size()), 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
